// File: rtl/prio_encoder_stream_if.sv
// Handshake bundle for prio_encoder_stream: request vector in, encoded indices out.
interface prio_encoder_stream_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;
  logic [N-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         zero;
  logic [W:0]   pend_cnt;

  modport master (
    output en, din, in_valid, out_ready,
    input  in_ready, y, out_valid, out_last, zero, pend_cnt
  );

  modport slave (
    input  en, din, in_valid, out_ready,
    output in_ready, y, out_valid, out_last, zero, pend_cnt
  );
endinterface

// File: rtl/prio_encoder_stream.sv
// Latches an N-bit request vector and streams the index of each set bit,
// one per handshake, in priority order, flagging the final index.
module prio_encoder_stream #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  prio_encoder_stream_if.slave bus
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] cleared;
  logic [W:0]   cnt_din;
  logic [W:0]   cnt_cleared;

  // Later loop iterations overwrite earlier hits, so the scan direction picks the winner.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++)
        if (v[i]) idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      c = c + {{W{1'b0}}, v[i]};
    return c;
  endfunction

  always_comb begin
    cleared     = pending & ~({{(N-1){1'b0}}, 1'b1} << bus.y);
    cnt_din     = popcount(bus.din);
    cnt_cleared = popcount(cleared);
  end

  assign bus.in_ready = rst_n && (state == IDLE) && bus.en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= '0;
      bus.y         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.pend_cnt  <= '0;
    end else begin
      bus.zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.en) begin
            if (bus.din != '0) begin
              pending       <= bus.din;
              bus.y         <= pick(bus.din);
              bus.pend_cnt  <= cnt_din;
              bus.out_last  <= (cnt_din == (W+1)'(1));
              bus.out_valid <= 1'b1;
              state         <= EMIT;
            end else begin
              bus.zero <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pending <= cleared;
            if (bus.out_last) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.pend_cnt  <= '0;
              state         <= IDLE;
            end else begin
              bus.y        <= pick(cleared);
              bus.pend_cnt <= cnt_cleared;
              bus.out_last <= (cnt_cleared == (W+1)'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
